// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
package dmem_access_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_REQ     = ST_REQ,
        S_WAIT_RD = ST_WAIT_RD,
        S_DONE    = ST_DONE
    } dmem_state_e;

    // Default bus timeout and the counter width that can hold it
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_CNT_W          = 7;

endpackage

// File: rtl/dmem_access_ctrl_timeout_cnt.sv
// Saturating bus-timeout counter. expired_o fires in the last allowed
// waiting cycle, so the access is aborted after exactly LIMIT cycles.
module dmem_timeout_cnt #(
    parameter int LIMIT = 64,
    parameter int CNT_W = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam bit              ENABLED = (LIMIT > 0);
    localparam logic [CNT_W-1:0] SAT    = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST   = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up while enabled, holding at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != SAT)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expired_o = ENABLED & en_i & (cnt_q >= LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Runs one aligned MEM-stage request against a variable-latency data memory,
// stalling the pipeline until it completes, times out, or is rejected.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    dmem_state_e state_q;
    logic [31:0] rdata_q, mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_mask_q;
    logic        rdata_valid_q, err_q, mem_ren_q, mem_wen_q;
    logic        req_any, illegal, waiting, cnt_clr, expired;

    assign req_any = i_req_ren | i_req_wen;
    // Both strobes, or a store that writes no byte, never reaches memory
    assign illegal = (i_req_ren & i_req_wen) | (i_req_wen & (i_req_mask == 4'h0));
    assign waiting = (state_q == S_REQ) || (state_q == S_WAIT_RD);
    assign cnt_clr = (state_q == S_IDLE) & req_any & ~illegal;

    // Stall must rise in the request cycle itself, so it is combinational
    assign o_stall = ((state_q == S_IDLE) & req_any) | waiting;

    dmem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (cnt_clr),
        .en_i      (waiting),
        .expired_o (expired)
    );

    // Access FSM with registered memory strobes and response pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_mask_q    <= '0;
            mem_ren_q     <= 1'b0;
            mem_wen_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        if (illegal) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= S_DONE;
                        end else begin
                            mem_addr_q  <= i_req_addr;
                            mem_wdata_q <= i_req_wdata;
                            mem_mask_q  <= i_req_mask;
                            mem_ren_q   <= i_req_ren;
                            mem_wen_q   <= i_req_wen;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A completing handshake beats a coincident timeout
                    if (i_mem_ready && mem_wen_q) begin
                        mem_wen_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (i_mem_ready && mem_ren_q && i_mem_rvalid) begin
                        mem_ren_q     <= 1'b0;
                        rdata_q       <= i_mem_rdata;
                        rdata_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else if (expired) begin
                        mem_ren_q <= 1'b0;
                        mem_wen_q <= 1'b0;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        state_q   <= S_DONE;
                    end else if (i_mem_ready) begin
                        mem_ren_q <= 1'b0;
                        state_q   <= S_WAIT_RD;
                    end
                end
                S_WAIT_RD: begin
                    if (i_mem_rvalid) begin
                        rdata_q       <= i_mem_rdata;
                        rdata_valid_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else if (expired) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= S_DONE;
                    end
                end
                // Request inputs here belong to the retiring instruction
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_rdata       = rdata_q;
    assign o_rdata_valid = rdata_valid_q;
    assign o_err         = err_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_mem_mask    = mem_mask_q;
    assign o_mem_ren     = mem_ren_q;
    assign o_mem_wen     = mem_wen_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: randomized transactions against a
// transaction-level timeline model, plus directed cases with literal results.
module tb_dmem_access_ctrl;
    localparam int T = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic [3:0]  req_mask;
    logic        req_ren, req_wen, mem_ready, mem_rvalid;
    logic        stall, rdata_valid, err, mem_ren, mem_wen;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;

    // second instance with a 4-cycle timeout and a memory that never answers
    logic        b_ren, b_wen, tie0;
    logic [31:0] b_addr, b_wdata, tie32;
    logic [3:0]  b_mask;
    logic        b_stall, b_rv, b_err, b_mren, b_mwen;
    logic [31:0] b_rdata, b_maddr, b_mwdata;
    logic [3:0]  b_mmask;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_mask(req_mask),
        .i_req_ren(req_ren), .i_req_wen(req_wen),
        .o_stall(stall), .o_rdata(rdata), .o_rdata_valid(rdata_valid), .o_err(err),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(7)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_addr(b_addr), .i_req_wdata(b_wdata), .i_req_mask(b_mask),
        .i_req_ren(b_ren), .i_req_wen(b_wen),
        .o_stall(b_stall), .o_rdata(b_rdata), .o_rdata_valid(b_rv), .o_err(b_err),
        .o_mem_addr(b_maddr), .o_mem_wdata(b_mwdata), .o_mem_mask(b_mmask),
        .o_mem_ren(b_mren), .o_mem_wen(b_mwen),
        .i_mem_ready(tie0), .i_mem_rvalid(tie0), .i_mem_rdata(tie32)
    );

    typedef struct packed {
        logic        stall, ren, wen, rv, err;
        logic [31:0] rdata, addr, wdata;
        logic [3:0]  mask;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic        ok;
    int          checks = 0, passed = 0;
    int          n_stall = 0, n_ren = 0, n_wen = 0, n_rv = 0, n_err = 0, n_acc = 0;
    logic [31:0] lw_addr = '0, lw_wdata = '0;
    logic [31:0] m_rdata = '0;
    bit          hi_noise = 1'b0;

    function automatic void push(input logic st, rn, wn, rv, er,
                                 input logic [31:0] rd, a, wd, input logic [3:0] m);
        exp_t e2;
        e2.stall = st; e2.ren = rn; e2.wen = wn; e2.rv = rv; e2.err = er;
        e2.rdata = rd; e2.addr = a; e2.wdata = wd; e2.mask = m;
        exp_q.push_back(e2);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got === expv) passed++;
        else $display("FAIL %s got %0h expected %0h", name, got, expv);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // Per-cycle compare against the model timeline, plus event counters
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall) n_stall++;
            if (mem_ren) n_ren++;
            if (mem_wen) begin n_wen++; lw_addr = mem_addr; lw_wdata = mem_wdata; end
            if (rdata_valid) n_rv++;
            if (err) n_err++;
            if ((mem_ren | mem_wen) & mem_ready) n_acc++;
        end
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            checks++;
            ok = (stall === ce.stall) && (mem_ren === ce.ren) && (mem_wen === ce.wen) &&
                 (rdata_valid === ce.rv) && (err === ce.err) && (rdata === ce.rdata);
            if ((ce.ren | ce.wen) &&
                !((mem_addr === ce.addr) && (mem_wdata === ce.wdata) && (mem_mask === ce.mask)))
                ok = 1'b0;
            if (ok) passed++;
            else $display("FAIL cycle t=%0t got st=%b rn=%b wn=%b rv=%b er=%b rd=%h a=%h wd=%h m=%h expected st=%b rn=%b wn=%b rv=%b er=%b rd=%h a=%h wd=%h m=%h",
                          $time, stall, mem_ren, mem_wen, rdata_valid, err, rdata, mem_addr, mem_wdata, mem_mask,
                          ce.stall, ce.ren, ce.wen, ce.rv, ce.err, ce.rdata, ce.addr, ce.wdata, ce.mask);
        end
    end

    function automatic logic noise();
        return hi_noise ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // One idle pipeline cycle: memory noise must be ignored
    task automatic idle_cyc();
        tick();
        req_ren = 0; req_wen = 0; req_addr = $urandom; req_wdata = $urandom; req_mask = 4'($urandom);
        mem_ready = noise(); mem_rvalid = noise(); mem_rdata = $urandom;
        push(0, 0, 0, 0, 0, m_rdata, 0, 0, 0);
        settle();
    endtask

    // One request. rd = waiting cycle index at which memory asserts ready,
    // rv = further cycles until rvalid. The whole access may wait at most T
    // cycles (indices 0..T-1) before it is aborted.
    task automatic txn(input bit is_rd, input bit is_wr, input logic [31:0] a, wd,
                       input logic [3:0] m, input int rd, input int rv, input logic [31:0] rdat);
        bit ill, to;
        int c, w, s;
        ill = (is_rd && is_wr) || (is_wr && m == 4'h0);
        to  = 1'b0;
        tick();
        req_ren = is_rd; req_wen = is_wr; req_addr = a; req_wdata = wd; req_mask = m;
        mem_ready = noise(); mem_rvalid = noise(); mem_rdata = $urandom;
        push(1, 0, 0, 0, 0, m_rdata, a, wd, m);
        if (!ill) begin
            c  = is_rd ? rd + rv : rd;
            w  = (c < T - 1) ? c : T - 1;
            s  = ((rd < T - 1) ? rd : T - 1) + 1;
            to = (c > T - 1);
            for (int k = 0; k <= w; k++) begin
                tick();
                mem_ready  = (k == rd) || (is_rd && k > rd && noise());
                mem_rvalid = is_rd ? (k == rd + rv) : noise();
                mem_rdata  = (is_rd && k == rd + rv) ? rdat : $urandom;
                push(1, is_rd && k < s, is_wr && k < s, 0, 0, m_rdata, a, wd, m);
            end
        end
        tick();
        if (!hi_noise) begin
            req_ren = 1'($urandom_range(0, 1)); req_wen = 1'($urandom_range(0, 1));
            req_addr = $urandom; req_wdata = $urandom; req_mask = 4'($urandom);
        end
        mem_ready = noise(); mem_rvalid = noise(); mem_rdata = $urandom;
        if (ill || to) m_rdata = '0;
        else if (is_rd) m_rdata = rdat;
        push(0, 0, 0, is_rd && !ill && !to, ill || to, m_rdata, a, wd, m);
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, w0, v0, e0, a0;
        int kind, rd, rv, gaps;
        logic [31:0] a;

        req_addr = '0; req_wdata = '0; req_mask = '0; req_ren = 0; req_wen = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        b_ren = 0; b_wen = 0; b_addr = '0; b_wdata = '0; b_mask = '0; tie0 = 0; tie32 = '0;

        #2;
        chk("reset_state", {stall, mem_ren, mem_wen, rdata_valid, err, rdata, mem_addr, mem_wdata, mem_mask}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Timeout=4, memory silent: 1 idle stall + 4 strobed cycles, then err
        for (int j = 0; j < 6; j++) begin
            tick();
            b_ren = (j <= 4); b_addr = 32'h200; b_mask = 4'hF;
            settle();
            chk($sformatf("tmo4_cyc%0d", j), {b_stall, b_mren, b_mwen, b_err, b_rv},
                {(j <= 4), (j >= 1 && j <= 4), 1'b0, (j == 5), 1'b0});
        end
        chk("tmo4_rdata", b_rdata, 32'h0);

        // Store with ready in first REQ cycle
        s0 = n_stall; w0 = n_wen; v0 = n_rv; e0 = n_err;
        txn(0, 1, 32'h100, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        chk("st_stall_cycles", n_stall - s0, 2);
        chk("st_wen_beats", n_wen - w0, 1);
        chk("st_addr", lw_addr, 32'h100);
        chk("st_wdata", lw_wdata, 32'hAABBCCDD);
        chk("st_no_rv_err", (n_rv - v0) + (n_err - e0), 0);

        // Load: ready after 1 cycle, rvalid 3 cycles after that
        s0 = n_stall; v0 = n_rv;
        txn(1, 0, 32'h104, 32'h0, 4'hF, 1, 3, 32'h12345678);
        chk("ld_rdata", rdata, 32'h12345678);
        chk("ld_rv_pulses", n_rv - v0, 1);
        chk("ld_stall_cycles", n_stall - s0, 6);

        // Back-to-back load then store, memory always ready/valid
        hi_noise = 1'b1; a0 = n_acc;
        txn(1, 0, 32'h108, 32'h0, 4'hF, 0, 0, 32'h0BADF00D);
        txn(0, 1, 32'h10C, 32'h55AA55AA, 4'h3, 0, 0, 0);
        hi_noise = 1'b0;
        chk("b2b_accepts", n_acc - a0, 2);

        // ren & wen together: rejected without touching memory
        s0 = n_stall; r0 = n_ren; w0 = n_wen; e0 = n_err;
        txn(1, 1, 32'h110, 32'h1, 4'hF, 0, 0, 0);
        chk("ill_no_strobe", (n_ren - r0) + (n_wen - w0), 0);
        chk("ill_err_pulse", n_err - e0, 1);
        chk("ill_stall_cycles", n_stall - s0, 1);
        chk("ill_rdata", rdata, 32'h0);

        // Reset while waiting for read data
        txn(1, 0, 32'h120, 32'h0, 4'hF, 0, 0, 32'h77777777);
        tick();
        req_ren = 1; req_wen = 0; req_addr = 32'h300; req_mask = 4'hF; mem_ready = 0; mem_rvalid = 0;
        push(1, 0, 0, 0, 0, m_rdata, 32'h300, req_wdata, 4'hF);
        tick(); mem_ready = 1;
        push(1, 1, 0, 0, 0, m_rdata, 32'h300, req_wdata, 4'hF);
        tick(); mem_ready = 0;
        push(1, 0, 0, 0, 0, m_rdata, 32'h300, req_wdata, 4'hF);
        settle();
        req_ren = 0; rst_n = 0; #1;
        chk("rst_async", {stall, mem_ren, mem_wen, rdata_valid, err, rdata, mem_addr, mem_wdata, mem_mask}, '0);
        m_rdata = '0;
        tick(); mem_rvalid = 1; mem_rdata = 32'hDEAD0001;
        settle();
        chk("rst_hold", {stall, mem_ren, mem_wen, rdata_valid, err, rdata}, '0);
        tick(); rst_n = 1;
        push(0, 0, 0, 0, 0, m_rdata, 0, 0, 0);
        settle();
        txn(1, 0, 32'h304, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D);
        chk("post_rst_rdata", rdata, 32'hCAFEF00D);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            gaps = $urandom_range(0, 2);
            repeat (gaps) idle_cyc();
            kind = $urandom_range(0, 9);
            rd = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 3);
            rv = $urandom_range(0, 4);
            a = $urandom; a[1:0] = 2'b00;
            case (kind)
                0, 1, 2, 3: txn(1, 0, a, $urandom, 4'($urandom_range(1, 15)), rd, rv, $urandom);
                4, 5, 6, 7: txn(0, 1, a, $urandom, 4'($urandom_range(1, 15)), rd, rv, $urandom);
                8:          txn(1, 1, a, $urandom, 4'($urandom_range(0, 15)), rd, rv, $urandom);
                default:    txn(0, 1, a, $urandom, 4'h0, rd, rv, $urandom);
            endcase
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
